// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the run/halt/single-step execution controller.
package exec_ctrl_pkg;

  localparam int EC_STATE_WIDTH = 3;

  typedef enum logic [EC_STATE_WIDTH-1:0] {
    EC_IDLE  = 3'd0,
    EC_RUN   = 3'd1,
    EC_STEP  = 3'd2,
    EC_BREAK = 3'd3,
    EC_DONE  = 3'd4
  } ec_state_e;

endpackage

// File: rtl/exec_ctrl_sat_counter.sv
// Saturating up-counter; clear has priority over increment.
module exec_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/exec_ctrl.sv
// Run/halt/single-step controller gating the datapath's lock enable,
// with PC breakpoint, instruction budget and retired-instruction count.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run_req,
  input  logic                      halt_req,
  input  logic                      step_req,
  input  logic                      clr_cnt,
  input  logic                      bp_en,
  input  logic [PC_W-1:0]           bp_addr,
  input  logic [CNT_W-1:0]          limit,
  input  logic [PC_W-1:0]           next_pc,
  output logic                      lock,
  output logic                      busy,
  output logic [EC_STATE_WIDTH-1:0] state_o,
  output logic                      bp_hit,
  output logic                      done,
  output logic [CNT_W-1:0]          instr_cnt
);

  ec_state_e state_q, state_d;
  logic      skip_q, skip_d;
  logic      lim_hit;
  logic      bp_stop;

  always_comb begin
    lim_hit = (limit != '0) && (instr_cnt >= limit);
    bp_stop = bp_en && (next_pc == bp_addr) && !skip_q;
    lock    = 1'b0;
    unique case (state_q)
      EC_RUN:  lock = !halt_req && !bp_stop && !lim_hit;
      EC_STEP: lock = !halt_req && !lim_hit;
      default: lock = 1'b0;
    endcase
  end

  // skip lets the instruction sitting at bp_addr retire once after a resume.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    unique case (state_q)
      EC_IDLE: begin
        if (step_req)     state_d = EC_STEP;
        else if (run_req) state_d = EC_RUN;
      end
      EC_RUN: begin
        if (halt_req)     state_d = EC_IDLE;
        else if (lim_hit) state_d = EC_DONE;
        else if (bp_stop) state_d = EC_BREAK;
        if (lock || (state_d != EC_RUN)) skip_d = 1'b0;
      end
      EC_STEP: begin
        if (!halt_req && lim_hit) state_d = EC_DONE;
        else                      state_d = EC_IDLE;
      end
      EC_BREAK: begin
        if (halt_req) begin
          state_d = EC_IDLE;
        end else if (step_req) begin
          state_d = EC_STEP;
        end else if (run_req) begin
          state_d = EC_RUN;
          skip_d  = 1'b1;
        end
      end
      EC_DONE: begin
        if (clr_cnt) state_d = EC_IDLE;
      end
      default: begin
        state_d = EC_IDLE;
        skip_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EC_IDLE;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  exec_ctrl_sat_counter #(
    .W (CNT_W)
  ) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (lock),
    .clr   (clr_cnt),
    .cnt   (instr_cnt)
  );

  assign state_o = state_q;
  assign busy    = (state_q == EC_RUN) || (state_q == EC_STEP);
  assign bp_hit  = (state_q == EC_BREAK);
  assign done    = (state_q == EC_DONE);

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: budget vector table, hand-written
// breakpoint/step/halt/reset/saturation sequences and randomized traffic.
module tb_exec_ctrl;

  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_BREAK = 3, M_DONE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0, clr_cnt = 1'b0;
  logic        bp_en = 1'b0;
  logic [15:0] bp_addr = '0;
  logic [31:0] limit = '0;
  logic [15:0] next_pc;
  logic        lock, busy, bp_hit, done;
  logic [2:0]  state_o;
  logic [31:0] instr_cnt;

  logic [3:0]  limit4 = '0;
  logic        lock4, busy4, bp_hit4, done4;
  logic [2:0]  state4;
  logic [3:0]  instr_cnt4;

  logic        dp_auto = 1'b0;
  logic [15:0] stim_pc = '0;
  logic [15:0] dp_pc;

  bit          cfg_bp_en = 1'b0;
  logic [15:0] cfg_bp_addr = '0;
  logic [31:0] cfg_limit = '0;
  bit          cfg_auto = 1'b0;
  logic [15:0] cfg_pc = '0;

  int total = 0;
  int bad = 0;
  int lock_pulses;

  int          m_state;
  bit          m_skip;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  exec_ctrl #(.PC_W(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .clr_cnt(clr_cnt), .bp_en(bp_en), .bp_addr(bp_addr),
    .limit(limit), .next_pc(next_pc), .lock(lock), .busy(busy),
    .state_o(state_o), .bp_hit(bp_hit), .done(done), .instr_cnt(instr_cnt)
  );

  exec_ctrl #(.PC_W(16), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .clr_cnt(clr_cnt), .bp_en(bp_en), .bp_addr(bp_addr),
    .limit(limit4), .next_pc(next_pc), .lock(lock4), .busy(busy4),
    .state_o(state4), .bp_hit(bp_hit4), .done(done4), .instr_cnt(instr_cnt4)
  );

  // Minimal datapath stand-in: fetch address advances a word per executed instruction.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)    dp_pc <= '0;
    else if (lock) dp_pc <= dp_pc + 16'd4;
  end
  assign next_pc = dp_auto ? dp_pc : stim_pc;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_lim();
    return (limit != 0) && (m_cnt >= limit);
  endfunction

  function automatic bit m_bp();
    return bp_en && (next_pc == bp_addr) && !m_skip;
  endfunction

  function automatic bit m_lock();
    if (m_state == M_RUN)  return !halt_req && !m_bp() && !m_lim();
    if (m_state == M_STEP) return !halt_req && !m_lim();
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_skip  = 1'b0;
    m_cnt   = '0;
  endtask

  // Predict the state after the coming edge from the current inputs.
  task automatic model_advance();
    bit lk  = m_lock();
    bit lim = m_lim();
    bit bp  = m_bp();
    int nxt = m_state;
    bit nsk = m_skip;
    case (m_state)
      M_IDLE:  if (step_req) nxt = M_STEP; else if (run_req) nxt = M_RUN;
      M_RUN: begin
        if (halt_req) nxt = M_IDLE; else if (lim) nxt = M_DONE; else if (bp) nxt = M_BREAK;
        if (lk || nxt != M_RUN) nsk = 1'b0;
      end
      M_STEP:  nxt = (!halt_req && lim) ? M_DONE : M_IDLE;
      M_BREAK: begin
        if (halt_req) nxt = M_IDLE;
        else if (step_req) nxt = M_STEP;
        else if (run_req) begin nxt = M_RUN; nsk = 1'b1; end
      end
      default: if (clr_cnt) nxt = M_IDLE;
    endcase
    if (clr_cnt) m_cnt = '0;
    else if (lk && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    m_state = nxt;
    m_skip  = nsk;
  endtask

  task automatic checkOutput();
    check("lock", {31'd0, lock}, {31'd0, m_lock()});
    check("state", {29'd0, state_o}, m_state);
    check("busy", {31'd0, busy}, {31'd0, (m_state == M_RUN) || (m_state == M_STEP)});
    check("bp_hit", {31'd0, bp_hit}, {31'd0, m_state == M_BREAK});
    check("done", {31'd0, done}, {31'd0, m_state == M_DONE});
    check("instr_cnt", instr_cnt, m_cnt);
  endtask

  // Drive one cycle of requests plus the current config, check, then predict.
  task automatic applyStimulus(input bit r, input bit h, input bit s, input bit c);
    @(negedge clk);
    run_req = r; halt_req = h; step_req = s; clr_cnt = c;
    bp_en = cfg_bp_en; bp_addr = cfg_bp_addr; limit = cfg_limit;
    dp_auto = cfg_auto; stim_pc = cfg_pc;
    #1;
    if (lock) lock_pulses++;
    checkOutput();
    model_advance();
  endtask

  task automatic doReset();
    @(negedge clk);
    run_req = 0; halt_req = 0; step_req = 0; clr_cnt = 0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          run, halt, step, clr;
    logic [2:0]  st;
    bit          lk;
    logic [31:0] cnt;
  } vec_t;

  function automatic vec_t mkv(bit r, bit h, bit s, bit c, logic [2:0] st, bit lk, int cnt);
    vec_t v;
    v.run = r; v.halt = h; v.step = s; v.clr = c; v.st = st; v.lk = lk; v.cnt = cnt;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    tbl[0]  = mkv(1,0,0,0, 3'd0, 0, 0);
    tbl[1]  = mkv(0,0,0,0, 3'd1, 1, 0);
    tbl[2]  = mkv(0,0,0,0, 3'd1, 1, 1);
    tbl[3]  = mkv(0,0,0,0, 3'd1, 1, 2);
    tbl[4]  = mkv(0,0,0,0, 3'd1, 1, 3);
    tbl[5]  = mkv(0,0,0,0, 3'd1, 1, 4);
    tbl[6]  = mkv(0,0,0,0, 3'd1, 0, 5);
    tbl[7]  = mkv(1,0,0,0, 3'd4, 0, 5);
    tbl[8]  = mkv(0,0,1,0, 3'd4, 0, 5);
    tbl[9]  = mkv(0,1,0,0, 3'd4, 0, 5);
    tbl[10] = mkv(0,0,0,1, 3'd4, 0, 5);
    tbl[11] = mkv(0,0,0,0, 3'd0, 0, 0);

    // Reset, free run, 4-bit saturation, asynchronous reset mid-run
    doReset();
    applyStimulus(0,0,0,0);
    check("rst_state", {29'd0, state_o}, 32'd0);
    check("rst_cnt", instr_cnt, 32'd0);
    applyStimulus(1,0,0,0);
    check("run_lat0", {31'd0, lock}, 32'd0);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(0,0,0,0);
      if (i == 1)  check("run_lat1", {31'd0, lock}, 32'd1);
      if (i == 11) check("run_cnt10", instr_cnt, 32'd10);
      if (i == 11) check("sat_pre", {28'd0, instr_cnt4}, 32'd10);
    end
    applyStimulus(0,0,0,0);
    check("sat_15", {28'd0, instr_cnt4}, 32'd15);
    applyStimulus(0,0,0,0);
    check("sat_hold", {28'd0, instr_cnt4}, 32'd15);
    #2 rst_n = 1'b0;
    #1;
    check("arst_lock", {31'd0, lock}, 32'd0);
    check("arst_cnt", instr_cnt, 32'd0);
    check("arst_state", {29'd0, state_o}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    // Budget of 5 instructions, DONE ignores requests, clr_cnt exits
    doReset();
    cfg_limit = 32'd5;
    lock_pulses = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].run, tbl[i].halt, tbl[i].step, tbl[i].clr);
      check($sformatf("tbl%0d_state", i), {29'd0, state_o}, {29'd0, tbl[i].st});
      check($sformatf("tbl%0d_lock", i), {31'd0, lock}, {31'd0, tbl[i].lk});
      check($sformatf("tbl%0d_cnt", i), instr_cnt, tbl[i].cnt);
    end
    check("budget_pulses", lock_pulses, 32'd5);
    cfg_limit = 32'd0;

    // Breakpoint at 0x0C from PC 0, then resume past it
    doReset();
    cfg_auto = 1'b1; cfg_bp_en = 1'b1; cfg_bp_addr = 16'h000C;
    applyStimulus(1,0,0,0);
    for (int i = 0; i < 5; i++) applyStimulus(0,0,0,0);
    check("bp_state", {29'd0, state_o}, 32'd3);
    check("bp_hit", {31'd0, bp_hit}, 32'd1);
    check("bp_cnt", instr_cnt, 32'd3);
    applyStimulus(1,0,0,0);
    applyStimulus(0,0,0,0);
    check("bp_resume_lock", {31'd0, lock}, 32'd1);
    applyStimulus(0,0,0,0);
    check("bp_resume_cnt", instr_cnt, 32'd4);
    check("bp_resume_state", {29'd0, state_o}, 32'd1);
    applyStimulus(0,0,0,0);

    // Hit a breakpoint again, then all three requests together in BREAK
    cfg_auto = 1'b0; cfg_pc = 16'h000C;
    applyStimulus(0,0,0,0);
    check("bp2_lock", {31'd0, lock}, 32'd0);
    applyStimulus(1,1,1,0);
    check("prio_state", {29'd0, state_o}, 32'd3);
    check("prio_lock", {31'd0, lock}, 32'd0);
    applyStimulus(0,0,0,0);
    check("prio_idle", {29'd0, state_o}, 32'd0);

    // clr_cnt on the same edge as an executed instruction
    cfg_pc = 16'h0020;
    applyStimulus(1,0,0,0);
    applyStimulus(0,0,0,1);
    check("clr_lock", {31'd0, lock}, 32'd1);
    applyStimulus(0,0,0,0);
    check("clr_wins", instr_cnt, 32'd0);

    // Held step_req: one instruction per two cycles; step ignores breakpoint
    applyStimulus(0,1,0,1);
    lock_pulses = 0;
    for (int i = 0; i < 6; i++) applyStimulus(0,0,1,0);
    check("step_pulses", lock_pulses, 32'd3);
    applyStimulus(0,0,0,0);
    check("step_cnt", instr_cnt, 32'd3);
    check("step_idle", {29'd0, state_o}, 32'd0);
    cfg_pc = 16'h000C;
    applyStimulus(0,0,1,0);
    applyStimulus(0,0,0,0);
    check("step_bp_lock", {31'd0, lock}, 32'd1);
    applyStimulus(0,0,0,0);
    check("step_bp_cnt", instr_cnt, 32'd4);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      if (i % 32 == 0) begin
        case ($urandom_range(0, 3))
          0: cfg_limit = 32'd0;
          1: cfg_limit = 32'd3;
          2: cfg_limit = 32'd6;
          default: cfg_limit = 32'd10;
        endcase
      end
      cfg_bp_en   = ($urandom_range(0, 3) != 0);
      cfg_bp_addr = 16'($urandom_range(0, 3) * 4);
      cfg_pc      = 16'($urandom_range(0, 3) * 4);
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Run/halt/single-step controller for the single-cycle datapath. Drives the datapath's `lock` enable so the datapath executes exactly one instruction on each rising clock edge where `lock` is high. Supports PC breakpoints, an instruction budget and a retired-instruction counter. Sits between the top level (or debug host) and `datapath`, and observes the datapath's next-fetch PC.

## Interface
Parameters:
- `PC_W`, 16: PC width; matches `PC_ADDR_WIDTH`.
- `CNT_W`, 32: width of the instruction counter and the budget.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `run_req` in 1: level or pulse; start or resume free-running execution.
- `halt_req` in 1: stop execution; highest priority.
- `step_req` in 1: execute exactly one instruction.
- `clr_cnt` in 1: clear `instr_cnt` and leave DONE.
- `bp_en` in 1: breakpoint enable.
- `bp_addr` in PC_W: breakpoint PC (byte address).
- `limit` in CNT_W: instruction budget; 0 means unlimited.
- `next_pc` in PC_W: the datapath's `Next_PC`, i.e. the address of the instruction that the next `lock` cycle fetches.
- `lock` out 1: datapath enable; combinational output of registered state and inputs.
- `busy` out 1: high in RUN or STEP.
- `state_o` out 3: current FSM state.
- `bp_hit` out 1: high while in BREAK.
- `done` out 1: high while in DONE.
- `instr_cnt` out CNT_W: number of retired instructions.

## Operation
- States and encodings: IDLE=0, RUN=1, STEP=2, BREAK=3, DONE=4.
- Request priority: `halt_req` > `step_req` > `run_req`.
- Derived conditions:
  - `lim_hit` = (`limit` != 0) && (`instr_cnt` >= `limit`).
  - `bp_stop` = `bp_en` && (`next_pc` == `bp_addr`) && !`skip`.
- `lock` by state:
  - RUN: `lock` = !`halt_req` && !`bp_stop` && !`lim_hit`.
  - STEP: `lock` = !`halt_req` && !`lim_hit`. Breakpoints are ignored in STEP.
  - All other states: `lock` = 0.
- IDLE transitions: `step_req` → STEP; else `run_req` → RUN. `halt_req` in IDLE has no effect.
- RUN transitions:
  - `halt_req` → IDLE.
  - else `lim_hit` → DONE.
  - else `bp_stop` → BREAK.
  - otherwise remain in RUN.
- STEP transitions, always after one cycle: `halt_req` → IDLE; else `lim_hit` → DONE; else → IDLE. Returning to IDLE means a held `step_req` produces one step every 2 cycles.
- BREAK transitions: `halt_req` → IDLE; `step_req` → STEP; `run_req` → RUN and sets `skip`.
- DONE transitions: `clr_cnt` → IDLE. Run, step and halt requests are ignored in DONE.
- `skip` flag: set on the BREAK→RUN transition. Cleared on the first RUN cycle with `lock`=1, or on leaving RUN. Its purpose is to let the instruction at `bp_addr` execute on resume.
- `instr_cnt` behaviour:
  - Increments on each edge where `lock`=1.
  - Saturates at all-ones and does not wrap.
  - `clr_cnt` clears it to 0 in any state. If `clr_cnt` and `lock` are both 1 on the same edge, the clear wins and the result is 0.
- Reset values (asynchronous, including mid-RUN): state IDLE, `skip` 0, `instr_cnt` 0. This gives `lock` 0, `busy` 0, `bp_hit` 0, `done` 0 and `state_o` 0 immediately on `rst_n` falling.

## Timing
- Request to enable: a request sampled on edge N makes `lock`=1 during the cycle after edge N, so the datapath executes on edge N+1. Latency is one cycle.
- Halt is immediate: `halt_req` forces `lock` low in the same cycle, so no instruction executes on that edge.
- Breakpoint timing: `next_pc` updates on the datapath edge. `bp_stop` is therefore valid before the following edge, and the instruction at `bp_addr` is not executed.
- Budget timing: with `limit`=L, exactly L instructions execute. Entry to DONE occurs on the edge after the L-th instruction.

## Structure
- Add to `global_def.h`: the `EC_IDLE`..`EC_DONE` state encodings and `EC_STATE_WIDTH` = 3.
- One natural sub-module, `sat_counter`: a parameterised CNT_W saturating up-counter with `inc`/`clr` inputs and clear priority. It is used for `instr_cnt`.
- Integration: `exec_ctrl.lock` drives `datapath.lock`. `datapath` exports `Next_PC` as `next_pc`.

## Test plan
- Reset and run: with `limit`=0 and `bp_en`=0, pulse `run_req`. `lock` rises 1 cycle later. After 10 cycles `instr_cnt`=10. Assert `rst_n`=0 mid-run → `lock`, `instr_cnt`, `state_o` all 0 immediately.
- Breakpoint: `bp_addr`=0x0C, run from PC 0. Exactly 3 instructions execute; state=BREAK, `bp_hit`=1, `instr_cnt`=3. Pulse `run_req` → the instruction at 0x0C executes (`instr_cnt`=4) and the run continues.
- Step: from IDLE, hold `step_req` for 6 cycles → 3 single-cycle `lock` pulses; `instr_cnt`=3. Step at `next_pc`==`bp_addr` with `bp_en`=1 → the instruction executes.
- Budget: `limit`=5, run → exactly 5 `lock` cycles, then `done`=1. `run_req` is ignored in DONE. `clr_cnt` → IDLE with `instr_cnt`=0.
- Halt priority and clear: `halt_req`, `step_req` and `run_req` asserted together in BREAK → IDLE with `lock`=0 that cycle. `clr_cnt` coincident with a `lock` cycle → `instr_cnt`=0.
- Saturation: with CNT_W=4 and `limit`=0, run 20 cycles → `instr_cnt`=15 and holds at 15.
